channel_receive_multi: RTL and testbench

//  Parametrised successor to the single-word channel receive unit; executes one CSP

---
 rtl/channel_receive_multi.sv | 141 ++++++++++++++
 tb/tb_channel_receive_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/channel_receive_multi.sv
// channel_receive_multi: one CSP receive of a MSG_WORDS-word message from a memory-resident channel.
// Optional build macro RECEIVE_CLEAR_PAYLOAD_EN zeroes the payload words after the header is cleared.
module channel_receive_multi #(
  parameter int unsigned addrBits  = 16,
  parameter int unsigned dataBits  = 16,
  parameter int unsigned MSG_WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addrBits-1:0] channel,
  input  logic [addrBits-1:0] rxPid,
  output logic                busy,
  output logic                finished,
  output logic [addrBits-1:0] address,
  output logic                readWriteMode,
  output logic [dataBits-1:0] dataIn,
  input  logic [dataBits-1:0] dataOut,
  output logic                shouldScheduleSender,
  output logic                shouldDescheduleReceiver,
  output logic [addrBits-1:0] scheduleTxPid,
  output logic                wordValid,
  output logic [7:0]          wordIndex,
  output logic [dataBits-1:0] deliveredWord,
  output logic                hasDeliveredMessage
);

  localparam logic [7:0] LAST_K = 8'(MSG_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, READ_HDR, WAIT_HDR, WRITE_PID, READ_PAY, CLEAR_HDR, CLEAR_PAY, DONE
  } state_t;

  state_t              r_state, w_next;
  logic [addrBits-1:0] r_chan, r_pid, r_txPid;
  logic [7:0]          r_k, r_rdIdx;
  logic                r_rdPend, r_sched, r_desched, r_hasMsg;
  logic [addrBits-1:0] w_payAddr;

  // Payload addresses wrap modulo 2^addrBits.
  assign w_payAddr = r_chan + addrBits'(1) + addrBits'(r_k);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_chan    <= '0;
      r_pid     <= '0;
      r_txPid   <= '0;
      r_k       <= '0;
      r_rdIdx   <= '0;
      r_rdPend  <= 1'b0;
      r_sched   <= 1'b0;
      r_desched <= 1'b0;
      r_hasMsg  <= 1'b0;
    end else begin
      r_state  <= w_next;
      // Read data arrives one cycle after the address, so delivery lags issue by one.
      r_rdPend <= (r_state == READ_PAY);
      r_rdIdx  <= (r_state == READ_PAY) ? r_k : '0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_chan    <= channel;
            r_pid     <= rxPid;
            r_k       <= '0;
            r_txPid   <= '0;
            r_sched   <= 1'b0;
            r_desched <= 1'b0;
            r_hasMsg  <= 1'b0;
          end
        end
        WAIT_HDR: begin
          if (dataOut != '0) r_txPid <= addrBits'(dataOut);
        end
        WRITE_PID: r_desched <= 1'b1;
        READ_PAY:  r_k <= (r_k == LAST_K) ? '0 : r_k + 8'd1;
        CLEAR_HDR: begin
          r_sched  <= 1'b1;
          r_hasMsg <= 1'b1;
        end
        CLEAR_PAY: r_k <= (r_k == LAST_K) ? '0 : r_k + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next        = r_state;
    address       = '0;
    readWriteMode = 1'b0;
    dataIn        = '0;
    finished      = 1'b0;
    case (r_state)
      IDLE:     if (start) w_next = READ_HDR;
      READ_HDR: begin
        address = r_chan;
        w_next  = WAIT_HDR;
      end
      WAIT_HDR: w_next = (dataOut == '0) ? WRITE_PID : READ_PAY;
      WRITE_PID: begin
        address       = r_chan;
        dataIn        = dataBits'(r_pid);
        readWriteMode = 1'b1;
        w_next        = DONE;
      end
      READ_PAY: begin
        address = w_payAddr;
        if (r_k == LAST_K) w_next = CLEAR_HDR;
      end
      CLEAR_HDR: begin
        address       = r_chan;
        readWriteMode = 1'b1;
`ifdef RECEIVE_CLEAR_PAYLOAD_EN
        w_next        = CLEAR_PAY;
`else
        w_next        = DONE;
`endif
      end
      CLEAR_PAY: begin
        address       = w_payAddr;
        readWriteMode = 1'b1;
        if (r_k == LAST_K) w_next = DONE;
      end
      DONE: begin
        finished = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy                     = (r_state != IDLE);
  assign wordValid                = r_rdPend;
  assign wordIndex                = r_rdIdx;
  assign deliveredWord            = r_rdPend ? dataOut : '0;
  assign shouldScheduleSender     = r_sched;
  assign shouldDescheduleReceiver = r_desched;
  assign scheduleTxPid            = r_txPid;
  assign hasDeliveredMessage      = r_hasMsg;

endmodule

// File: tb/tb_channel_receive_multi.sv
// Scoreboard bench for channel_receive_multi: 8-bit addresses so channel wrap is reachable.
`timescale 1ns/1ps
module tb_channel_receive_multi;
  localparam int unsigned AB = 8;
  localparam int unsigned DB = 16;
  localparam int unsigned M  = 4;
`ifdef RECEIVE_CLEAR_PAYLOAD_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AB-1:0] channel, rxPid, address, scheduleTxPid;
  logic          busy, finished, readWriteMode, wordValid, hasDeliveredMessage;
  logic [DB-1:0] dataIn, dataOut, deliveredWord;
  logic          shouldScheduleSender, shouldDescheduleReceiver;
  logic [7:0]    wordIndex;

  always #5 clk = ~clk;

  channel_receive_multi #(.addrBits(AB), .dataBits(DB), .MSG_WORDS(M)) dut (
    .clk(clk), .reset(reset_n), .start(start), .channel(channel), .rxPid(rxPid),
    .busy(busy), .finished(finished), .address(address), .readWriteMode(readWriteMode),
    .dataIn(dataIn), .dataOut(dataOut), .shouldScheduleSender(shouldScheduleSender),
    .shouldDescheduleReceiver(shouldDescheduleReceiver), .scheduleTxPid(scheduleTxPid),
    .wordValid(wordValid), .wordIndex(wordIndex), .deliveredWord(deliveredWord),
    .hasDeliveredMessage(hasDeliveredMessage)
  );

  // Memory with one-cycle read latency and a backdoor write port used only while idle.
  logic [DB-1:0] ram [256];
  logic          bd_we = 1'b0;
  logic [AB-1:0] bd_addr = '0;
  logic [DB-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (readWriteMode) ram[address] <= dataIn;
    else if (bd_we) ram[bd_addr] <= bd_data;
    dataOut <= ram[address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [DB-1:0] data; int at; } word_t;
  typedef struct { int at; bit sched; bit desched; bit has; logic [AB-1:0] tx; } fin_t;
  word_t wq[$];
  fin_t  fq[$];
  logic [DB-1:0] mdl [256];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a word or a completion.
  word_t mw;
  fin_t  mf;
  always @(negedge clk) begin
    if (reset_n) begin
      if (wordValid) begin
        if (wq.size() == 0) check("unexpected_word", 32'(wordValid), 0);
        else begin
          mw = wq.pop_front();
          check("word_index", 32'(wordIndex), 32'(mw.idx));
          check("word_data", 32'(deliveredWord), 32'(mw.data));
          check("word_edge", 32'(cyc + 1), 32'(mw.at));
        end
      end
      if (finished) begin
        if (fq.size() == 0) check("unexpected_finished", 32'(finished), 0);
        else begin
          mf = fq.pop_front();
          check("finish_edge", 32'(cyc + 1), 32'(mf.at));
          check("busy_in_done", 32'(busy), 1);
          check("schedule", 32'(shouldScheduleSender), 32'(mf.sched));
          check("deschedule", 32'(shouldDescheduleReceiver), 32'(mf.desched));
          check("has_message", 32'(hasDeliveredMessage), 32'(mf.has));
          check("tx_pid", 32'(scheduleTxPid), 32'(mf.tx));
        end
      end
    end
  end

  task automatic poke(input logic [AB-1:0] a, input logic [DB-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    mdl[a] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_finished"}, 32'(finished), 0);
    check({tag, "_address"}, 32'(address), 0);
    check({tag, "_rw"}, 32'(readWriteMode), 0);
    check({tag, "_dataIn"}, 32'(dataIn), 0);
    check({tag, "_wordValid"}, 32'(wordValid), 0);
    check({tag, "_wordIndex"}, 32'(wordIndex), 0);
    check({tag, "_delivered"}, 32'(deliveredWord), 0);
    check({tag, "_flags"}, 32'({shouldScheduleSender, shouldDescheduleReceiver, hasDeliveredMessage}), 0);
    check({tag, "_txpid"}, 32'(scheduleTxPid), 0);
  endtask

  // One receive; pulse_at>0 re-pulses start (with junk inputs) that many cycles after t0.
  task automatic run_op(input logic [AB-1:0] ch, input logic [AB-1:0] pid, input logic [DB-1:0] hdr,
                        input logic [DB-1:0] pay [M], input int pulse_at);
    int t0, lat, n;
    bit done;
    fin_t f;
    word_t w;
    logic [AB-1:0] pa;
    poke(ch, hdr);
    for (int k = 0; k < int'(M); k++) poke(AB'(int'(ch) + 1 + k), pay[k]);
    @(negedge clk);
    bd_we = 1'b0;
    channel = ch; rxPid = pid; start = 1'b1;
    t0 = cyc + 1;
    if (hdr == '0) begin
      lat = 4;
      f = '{at: t0 + lat, sched: 1'b0, desched: 1'b1, has: 1'b0, tx: '0};
      mdl[ch] = DB'(pid);
    end else begin
      lat = 4 + int'(M) + (CLR ? int'(M) : 0);
      for (int k = 0; k < int'(M); k++) begin
        w = '{idx: k, data: pay[k], at: t0 + 4 + k};
        wq.push_back(w);
        if (CLR) begin
          pa = AB'(int'(ch) + 1 + k);
          mdl[pa] = '0;
        end
      end
      f = '{at: t0 + lat, sched: 1'b1, desched: 1'b0, has: 1'b1, tx: AB'(hdr)};
      mdl[ch] = '0;
    end
    fq.push_back(f);
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (n == pulse_at) begin
        start = 1'b1; channel = ~ch; rxPid = 8'hAA;
      end else start = 1'b0;
      if (finished) done = 1'b1;
    end
    if (!done) check("finish_timeout", 0, 1);
    check("ram_header", 32'(ram[ch]), 32'(mdl[ch]));
    for (int k = 0; k < int'(M); k++) begin
      pa = AB'(int'(ch) + 1 + k);
      check("ram_payload", 32'(ram[pa]), 32'(mdl[pa]));
    end
    @(negedge clk);
    check("busy_after_done", 32'(busy), 0);
    check("finished_single_pulse", 32'(finished), 0);
  endtask

  logic [DB-1:0] p [M];
  logic [AB-1:0] rch;
  logic [DB-1:0] rhdr;

  initial begin
    reset_n = 1'b0; start = 1'b0; channel = '0; rxPid = '0;
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Empty channel.
    p = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_op(8'd2, 8'd7, 16'd0, p, 0);
    // Waiting sender.
    p = '{16'd42, 16'd43, 16'd44, 16'd45};
    run_op(8'd8, 8'd3, 16'd8, p, 0);
    // Payload wraps past the top of memory.
    p = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_op(8'hFE, 8'd9, 16'd5, p, 0);
    // Start re-pulsed at t2 is ignored.
    p = '{16'd7, 16'd8, 16'd9, 16'd10};
    run_op(8'd20, 8'd4, 16'd11, p, 2);

    // Reset during the first payload read cycle aborts without touching the header.
    poke(8'd40, 16'd33);
    for (int k = 0; k < int'(M); k++) poke(AB'(41 + k), 16'(100 + k));
    @(negedge clk);
    bd_we = 1'b0; channel = 8'd40; rxPid = 8'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midop_reset");
    @(negedge clk);
    reset_n = 1'b1;
    check("reset_header_kept", 32'(ram[8'd40]), 32'(mdl[8'd40]));
    repeat (2) @(negedge clk);
    check("no_word_after_abort", 32'(wordValid), 0);

    for (int i = 0; i < 40; i++) begin
      rch  = AB'($urandom_range(0, 255));
      rhdr = ($urandom_range(0, 1) == 0) ? '0 : DB'($urandom_range(1, 255));
      for (int k = 0; k < int'(M); k++) p[k] = DB'($urandom);
      run_op(rch, AB'($urandom_range(1, 255)), rhdr, p,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("word_queue_drained", 32'(wq.size()), 0);
    check("finish_queue_drained", 32'(fq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
